// File: rtl/payload_fifo_drain.sv
// Read-side drain controller for the payload FIFO: pops LENGTH bytes per command and
// either streams them on a valid/ready byte port with a last marker or discards them.
module payload_fifo_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  drop,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    input  logic                  fifo_empty,
    output logic                  fifo_re,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  tx_last,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        DISCARD = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [LEN_WIDTH-1:0]    remaining_reg;
    logic [DATA_WIDTH-1:0]   tx_data_reg;
    logic                    tx_valid_reg;
    logic                    tx_last_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    pop;
    logic                    handshake;
    logic                    rem_nonzero;
    logic                    rem_is_one;

    assign handshake   = tx_valid_reg && tx_ready;
    assign rem_nonzero = (remaining_reg != '0);
    assign rem_is_one  = (remaining_reg == LEN_WIDTH'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                // A zero-length command passes through DISCARD with nothing to pop,
                // which places its DONE pulse two cycles after the accepted START.
                if (start) begin
                    if (length == '0 || drop) begin
                        state_next = DISCARD;
                    end else begin
                        state_next = STREAM;
                    end
                end
            end
            STREAM: begin
                if (handshake && tx_last_reg) begin
                    state_next = FINISH;
                end
            end
            DISCARD: begin
                if (!rem_nonzero || (pop && rem_is_one)) begin
                    state_next = FINISH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop = 1'b0;
        case (state_reg)
            STREAM:  pop = rem_nonzero && !fifo_empty && (!tx_valid_reg || tx_ready);
            DISCARD: pop = rem_nonzero && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining_reg <= '0;
            tx_data_reg   <= '0;
            tx_valid_reg  <= 1'b0;
            tx_last_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            if (state_reg == IDLE && start) begin
                remaining_reg <= length;
            end else if (pop) begin
                remaining_reg <= remaining_reg - LEN_WIDTH'(1);
            end

            if (pop && state_reg == STREAM) begin
                tx_data_reg  <= fifo_q;
                tx_valid_reg <= 1'b1;
                tx_last_reg  <= rem_is_one;
            end else if (handshake) begin
                tx_valid_reg <= 1'b0;
                tx_last_reg  <= 1'b0;
            end

            busy_reg <= (state_next == STREAM) || (state_next == DISCARD);
            done_reg <= (state_next == FINISH);
        end
    end

    assign fifo_re  = pop;
    assign tx_data  = tx_data_reg;
    assign tx_valid = tx_valid_reg;
    assign tx_last  = tx_last_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_payload_fifo_drain.sv
// Bench for payload_fifo_drain: queue-modelled FWFT FIFO, scoreboard of expected bytes
// derived from the written byte sequence, directed timing windows plus random commands.
module tb_payload_fifo_drain;
    localparam int DW = 8;
    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] length = '0;
    logic          drop = 1'b0;
    logic [DW-1:0] fifo_q = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_re;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_last;
    logic          tx_ready = 1'b1;
    logic          busy;
    logic          done;

    payload_fifo_drain #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .length(length), .drop(drop),
        .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_re(fifo_re),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] src [0:8191];
    logic [7:0] fifo [$];
    exp_t       exp_q [$];
    int         wr_req = 0;
    int         wr_done = 0;
    int         rd_model = 0;
    int         done_cnt = 0;
    int         cmds = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Environment FIFO: pops on fifo_re, absorbs requested writes, FWFT head.
    initial begin
        forever begin
            @(posedge clk);
            if (fifo_re && fifo.size() > 0) void'(fifo.pop_front());
            while (wr_done < wr_req) begin
                fifo.push_back(src[wr_done]);
                wr_done++;
            end
            fifo_q     <= (fifo.size() > 0) ? fifo[0] : '0;
            fifo_empty <= (fifo.size() == 0);
        end
    end

    // Monitor: byte scoreboard, stall stability, underflow, DONE counting.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        exp_t       e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (fifo_re) check("no_underflow", fifo_empty, 0);
                if (prev_stall) begin
                    check("hold_valid", tx_valid, 1);
                    check("hold_data", tx_data, prev_data);
                    check("hold_last", tx_last, prev_last);
                end
                if (tx_valid && !tx_ready) check("stall_no_pop", fifo_re, 0);
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                prev_last  = tx_last;
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%0h with none outstanding at %0t", tx_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_data", tx_data, e.data);
                        check("tx_last", tx_last, e.last);
                    end
                end
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic write_bytes(input int n);
        wr_req += n;
    endtask

    task automatic issue(input int len, input bit d);
        exp_t e;
        @(posedge clk); #1;
        start  = 1'b1;
        length = len[LW-1:0];
        drop   = d;
        if (!d) begin
            for (int i = 0; i < len; i++) begin
                e.data = src[rd_model + i];
                e.last = (i == len - 1);
                exp_q.push_back(e);
            end
        end
        rd_model += len;
        cmds++;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic observe(input int ncyc, input int lo, input int hi, input int rs_cyc,
                           output logic [31:0] re_m, output logic [31:0] val_m,
                           output logic [31:0] done_m, output logic [31:0] busy_m);
        re_m = '0; val_m = '0; done_m = '0; busy_m = '0;
        for (int c = 1; c <= ncyc; c++) begin
            tx_ready = !(c >= lo && c <= hi);
            if (c == rs_cyc) begin
                start = 1'b1; length = '0; drop = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            re_m[c] = fifo_re; val_m[c] = tx_valid; done_m[c] = done; busy_m[c] = busy;
            @(posedge clk); #1;
        end
        start = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic wait_done(input int bound, input bit rnd, input int need, output int cyc);
        int k;
        cyc = 0;
        while (cyc < bound && done_cnt < cmds) begin
            if (rnd) begin
                tx_ready = ($urandom % 4) != 0;
                k = $urandom % 3;
                if (k > need) k = need;
                write_bytes(k);
                need -= k;
            end
            @(posedge clk); #1;
            cyc++;
        end
        tx_ready = 1'b1;
        check("done_seen", done_cnt >= cmds, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_fifo_re"}, fifo_re, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_tx_last"}, tx_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        logic [31:0] re_m, val_m, done_m, busy_m;
        int cyc, len, occ, need, base, dc;
        bit d;
        for (int i = 0; i < 8192; i++) src[i] = 8'($urandom);

        // Reset values
        write_bytes(2);
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset_n = 1'b1;
        rd_model = 0;
        issue(2, 1'b1);
        wait_done(20, 1'b0, 0, cyc);

        // Stream with no backpressure
        src[wr_req] = 8'h11; src[wr_req+1] = 8'h22; src[wr_req+2] = 8'h33; src[wr_req+3] = 8'h44;
        write_bytes(4);
        issue(4, 1'b0);
        observe(8, 0, -1, 0, re_m, val_m, done_m, busy_m);
        check("stream_re", re_m, 32'h1E);
        check("stream_valid", val_m, 32'h3C);
        check("stream_done", done_m, 32'h40);
        check("stream_busy", busy_m, 32'h3E);
        check("stream_sb_empty", exp_q.size(), 0);

        // Backpressure in cycles 2..4
        write_bytes(4);
        issue(4, 1'b0);
        observe(10, 2, 4, 0, re_m, val_m, done_m, busy_m);
        check("bp_re", re_m, 32'hE2);
        check("bp_valid", val_m, 32'h1FC);
        check("bp_done", done_m, 32'h200);
        check("bp_busy", busy_m, 32'h1FE);

        // START pulsed while streaming, then during FINISH: both ignored
        write_bytes(4);
        issue(4, 1'b0);
        observe(10, 0, -1, 2, re_m, val_m, done_m, busy_m);
        check("ign_busy_re", re_m, 32'h1E);
        check("ign_busy_done", done_m, 32'h40);
        write_bytes(4);
        issue(4, 1'b0);
        observe(10, 0, -1, 6, re_m, val_m, done_m, busy_m);
        check("ign_finish_done", done_m, 32'h40);
        check("ign_finish_busy", busy_m, 32'h3E);

        // Zero-length command
        issue(0, 1'b0);
        observe(5, 0, -1, 0, re_m, val_m, done_m, busy_m);
        check("len0_re", re_m, 0);
        check("len0_valid", val_m, 0);
        check("len0_done", done_m, 32'h4);
        check("len0_busy", busy_m, 32'h2);

        // Discard three of four bytes
        src[wr_req] = 8'hA0; src[wr_req+1] = 8'hA1; src[wr_req+2] = 8'hA2; src[wr_req+3] = 8'hB0;
        write_bytes(4);
        issue(3, 1'b1);
        observe(6, 0, -1, 0, re_m, val_m, done_m, busy_m);
        check("discard_re", re_m, 32'hE);
        check("discard_valid", val_m, 0);
        check("discard_done", done_m, 32'h10);
        check("discard_busy", busy_m, 32'hE);
        check("discard_left", fifo.size(), 1);
        if (fifo.size() > 0) check("discard_head", fifo[0], 8'hB0);
        issue(1, 1'b0);
        wait_done(20, 1'b0, 0, cyc);

        // FIFO underrun: 2 of 3 bytes present, third written later
        write_bytes(2);
        issue(3, 1'b0);
        observe(6, 0, -1, 0, re_m, val_m, done_m, busy_m);
        check("underrun_re", re_m, 32'h6);
        check("underrun_valid", val_m, 32'hC);
        check("underrun_done", done_m, 0);
        check("underrun_busy", busy_m, 32'h7E);
        write_bytes(1);
        wait_done(20, 1'b0, 0, cyc);
        check("underrun_sb_empty", exp_q.size(), 0);

        // Reset after 2 of 5 bytes popped
        write_bytes(5);
        base = rd_model;
        issue(5, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        exp_q.delete();
        rd_model = base + 2;
        cmds--;
        dc = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_fifo_left", fifo.size(), 3);
        check("midreset_no_done", done_cnt, dc);
        reset_n = 1'b1;
        issue(3, 1'b0);
        wait_done(40, 1'b0, 0, cyc);
        check("post_reset_sb_empty", exp_q.size(), 0);

        // Random commands with random backpressure and trickled writes
        for (int n = 0; n < 40; n++) begin
            len = (($urandom % 4) == 0) ? int'($urandom % 3) : 3 + int'($urandom % 38);
            d = ($urandom % 3) == 0;
            occ = wr_req - rd_model;
            need = (len > occ) ? len - occ : 0;
            issue(len, d);
            wait_done(len * 8 + 50, 1'b1, need, cyc);
            check("rand_sb_empty", exp_q.size(), 0);
        end

        // Full-depth stream and discard
        occ = wr_req - rd_model;
        issue(1024, 1'b0);
        wait_done(6000, 1'b1, 1024 - occ, cyc);
        check("stream1024_sb_empty", exp_q.size(), 0);
        occ = wr_req - rd_model;
        write_bytes(1024 - occ);
        repeat (2) @(posedge clk);
        issue(1024, 1'b1);
        wait_done(1200, 1'b0, 0, cyc);
        check("discard1024_latency", cyc, 1025);
        check("discard1024_fifo_empty", fifo.size(), 0);

        repeat (3) @(posedge clk);
        #1;
        check("done_count", done_cnt, cmds);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
